// File: rtl/store_buf.sv
// store_buf: in-order store buffer between writeback and dcache,
// with load hazard detection (address match, same-cycle push, uncached drain).
module store_buf #(
   parameter int DEPTH = 4,
   parameter int AW    = 32,
   parameter int DW    = 64,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = PW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          phi2,
   input  logic          push,
   input  logic [AW-1:0] push_pa,
   input  logic [DW-1:0] push_data,
   input  logic [2:0]    push_sz,
   input  logic          push_cache,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count,
   output logic          ovfl,
   output logic          dcwrite,
   output logic [AW-1:0] dcpa,
   output logic [DW-1:0] dcwdata,
   output logic [2:0]    dcsz,
   output logic          dccache,
   input  logic          dcbusy,
   input  logic          ldreq,
   input  logic [AW-1:0] ldpa,
   input  logic          ldcache,
   output logic          ldconf
);
   logic [AW-1:0]    r_pa    [DEPTH];
   logic [DW-1:0]    r_data  [DEPTH];
   logic [2:0]       r_sz    [DEPTH];
   logic             r_cache [DEPTH];
   logic [PW-1:0]    r_head, r_tail;
   logic [CW-1:0]    r_count;
   logic             r_ovfl;
   logic             w_pop, w_push;
   logic [DEPTH-1:0] w_hit;
   logic             w_unused;

   assign empty    = r_count == '0;
   assign full     = r_count == CW'(DEPTH);
   assign count    = r_count;
   assign ovfl     = r_ovfl;
   assign dcwrite  = !empty;
   assign dcpa     = r_pa[r_head];
   assign dcwdata  = r_data[r_head];
   assign dcsz     = r_sz[r_head];
   assign dccache  = r_cache[r_head];
   assign w_pop    = phi2 && dcwrite && !dcbusy;
   assign w_push   = phi2 && push && (!full || w_pop);
   assign w_unused = ^ldpa[2:0];

   // An entry is live when its distance from head is below count.
   always_comb begin
      for (int i = 0; i < DEPTH; i++)
         w_hit[i] = ({1'b0, PW'(i) - r_head} < r_count) && (r_pa[i][AW-1:3] == ldpa[AW-1:3]);
   end

   assign ldconf = ldreq && (|w_hit || (push && push_pa[AW-1:3] == ldpa[AW-1:3]) ||
                             (!ldcache && (dcwrite || push)));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_ovfl  <= 1'b0;
      end else begin
         if (w_pop) r_head <= r_head + PW'(1);
         if (w_push) r_tail <= r_tail + PW'(1);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
         if (phi2 && push && !w_push) r_ovfl <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_pa[r_tail]    <= push_pa;
         r_data[r_tail]  <= push_data;
         r_sz[r_tail]    <= push_sz;
         r_cache[r_tail] <= push_cache;
      end
   end
endmodule

// File: tb/tb_store_buf.sv
// tb_store_buf: directed scenarios plus randomized traffic checked against a queue model.
module tb_store_buf;
   localparam int DEPTH = 4, AW = 32, DW = 64, CW = 3;
   logic          clk = 0, reset = 1, phi2 = 0, push = 0, push_cache = 0;
   logic          dcbusy = 0, ldreq = 0, ldcache = 1;
   logic [AW-1:0] push_pa = 0, ldpa = 0;
   logic [DW-1:0] push_data = 0;
   logic [2:0]    push_sz = 0;
   logic          full, empty, ovfl, dcwrite, dccache, ldconf;
   logic [CW-1:0] count;
   logic [AW-1:0] dcpa;
   logic [DW-1:0] dcwdata;
   logic [2:0]    dcsz;

   typedef struct packed {logic [AW-1:0] pa; logic [DW-1:0] d; logic [2:0] sz; logic c;} ent_t;
   ent_t q[$];
   bit   m_ovfl;
   int   n_chk, n_fail;

   store_buf #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk(clk), .reset(reset), .phi2(phi2), .push(push), .push_pa(push_pa),
      .push_data(push_data), .push_sz(push_sz), .push_cache(push_cache),
      .full(full), .empty(empty), .count(count), .ovfl(ovfl), .dcwrite(dcwrite),
      .dcpa(dcpa), .dcwdata(dcwdata), .dcsz(dcsz), .dccache(dccache),
      .dcbusy(dcbusy), .ldreq(ldreq), .ldpa(ldpa), .ldcache(ldcache), .ldconf(ldconf));

   always #5 clk = ~clk;

   // Apply the FIFO rules for the coming rising edge, then move to the next falling edge.
   task automatic tick();
      bit pop, acc;
      pop = 0;
      acc = 0;
      if (phi2) begin
         pop = q.size() > 0 && !dcbusy;
         acc = push && (q.size() < DEPTH || pop);
         if (pop) q.delete(0);
         if (acc) q.push_back({push_pa, push_data, push_sz, push_cache});
         if (push && !acc) m_ovfl = 1;
      end
      @(negedge clk);
   endtask

   function automatic bit exp_ldconf();
      bit m = 0;
      foreach (q[i]) if (q[i].pa[AW-1:3] == ldpa[AW-1:3]) m = 1;
      return ldreq && (m || (push && push_pa[AW-1:3] == ldpa[AW-1:3]) ||
                       (!ldcache && (q.size() > 0 || push)));
   endfunction

   task automatic set_push(input logic [AW-1:0] pa, input logic [DW-1:0] d);
      push = 1; push_pa = pa; push_data = d; push_sz = 3'd7; push_cache = 1;
   endtask

   task automatic test_reset();
      #1;
      n_chk++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", empty); end
      n_chk++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", full); end
      n_chk++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
      n_chk++; if (dcwrite !== 1'b0) begin n_fail++; $display("FAIL reset_dcwrite got %b want 0", dcwrite); end
      n_chk++; if (ovfl !== 1'b0) begin n_fail++; $display("FAIL reset_ovfl got %b want 0", ovfl); end
      @(negedge clk);
      reset = 0;
      q.delete();
      m_ovfl = 0;
   endtask

   task automatic test_drain();
      phi2 = 1; dcbusy = 0;
      set_push(32'h100, 64'h11);
      #1;
      n_chk++; if (dcwrite !== 1'b0) begin n_fail++; $display("FAIL no_bypass dcwrite got %b want 0", dcwrite); end
      tick();
      n_chk++; if (dcwrite !== 1'b1 || dcpa !== 32'h100 || dcwdata !== 64'h11)
         begin n_fail++; $display("FAIL drain_first got %b/%h/%h want 1/100/11", dcwrite, dcpa, dcwdata); end
      set_push(32'h108, 64'h22);
      tick();
      push = 0;
      n_chk++; if (dcwrite !== 1'b1 || dcpa !== 32'h108 || dcwdata !== 64'h22 || count !== 3'd1)
         begin n_fail++; $display("FAIL drain_second got %b/%h/%h/%0d want 1/108/22/1", dcwrite, dcpa, dcwdata, count); end
      tick();
      n_chk++; if (empty !== 1'b1 || dcwrite !== 1'b0)
         begin n_fail++; $display("FAIL drain_empty got %b/%b want 1/0", empty, dcwrite); end
   endtask

   task automatic test_overflow();
      logic [AW-1:0] exp_seq [5];
      int n;
      exp_seq[0] = 32'h300; exp_seq[1] = 32'h308; exp_seq[2] = 32'h310;
      exp_seq[3] = 32'h318; exp_seq[4] = 32'h200;
      dcbusy = 1;
      for (int i = 0; i < 4; i++) begin
         set_push(32'h300 + 32'(i * 8), 64'hA0 + 64'(i));
         tick();
      end
      n_chk++; if (full !== 1'b1 || count !== 3'd4)
         begin n_fail++; $display("FAIL fill got full=%b count=%0d want 1/4", full, count); end
      n_chk++; if (ovfl !== 1'b0) begin n_fail++; $display("FAIL early_ovfl got %b want 0", ovfl); end
      set_push(32'h400, 64'hFF);
      tick();
      n_chk++; if (ovfl !== 1'b1 || count !== 3'd4 || dcpa !== 32'h300)
         begin n_fail++; $display("FAIL drop got ovfl=%b count=%0d head=%h want 1/4/300", ovfl, count, dcpa); end
      dcbusy = 0;
      set_push(32'h200, 64'hB0);
      tick();
      push = 0;
      n_chk++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_push_pop count got %0d want 4", count); end
      n = 1;
      for (int i = 0; i < 10 && dcwrite; i++) begin
         n_chk++; if (n > 4 || dcpa !== exp_seq[n])
            begin n_fail++; $display("FAIL order idx=%0d got %h want %h", n, dcpa, exp_seq[n % 5]); end
         n++;
         tick();
      end
      n_chk++; if (n !== 5 || empty !== 1'b1)
         begin n_fail++; $display("FAIL drained_count got %0d empty=%b want 4/1", n - 1, empty); end
      n_chk++; if (ovfl !== 1'b1) begin n_fail++; $display("FAIL ovfl_sticky got %b want 1", ovfl); end
   endtask

   task automatic test_hazard();
      dcbusy = 1;
      set_push(32'h1004, 64'h5);
      tick();
      push = 0; phi2 = 0;
      ldreq = 1; ldcache = 1; ldpa = 32'h1000;
      #1;
      n_chk++; if (ldconf !== 1'b1) begin n_fail++; $display("FAIL ld_match got %b want 1", ldconf); end
      ldpa = 32'h1008;
      #1;
      n_chk++; if (ldconf !== 1'b0) begin n_fail++; $display("FAIL ld_nomatch got %b want 0", ldconf); end
      set_push(32'h1008, 64'h6);
      #1;
      n_chk++; if (ldconf !== 1'b1) begin n_fail++; $display("FAIL ld_samecycle got %b want 1", ldconf); end
      push = 0; ldreq = 0;
      tick();
   endtask

   task automatic test_uncached();
      int n;
      phi2 = 1;
      set_push(32'h2000, 64'h7);
      tick();
      push = 0; phi2 = 0;
      ldreq = 1; ldcache = 0; ldpa = 32'h5000;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_chk++; if (count !== 3'd2 || ldconf !== 1'b1)
            begin n_fail++; $display("FAIL phi2_hold got count=%0d ldconf=%b want 2/1", count, ldconf); end
         tick();
      end
      phi2 = 1; dcbusy = 0;
      n = 0;
      for (int i = 0; i < 10 && q.size() > 0; i++) begin
         #1;
         n_chk++; if (ldconf !== 1'b1) begin n_fail++; $display("FAIL unc_wait got %b want 1", ldconf); end
         n++;
         tick();
      end
      #1;
      n_chk++; if (n !== 2 || count !== 3'd0 || ldconf !== 1'b0)
         begin n_fail++; $display("FAIL unc_release got cycles=%0d count=%0d ldconf=%b want 2/0/0", n, count, ldconf); end
      ldreq = 0; ldcache = 1;
      tick();
   endtask

   task automatic test_reset_mid();
      dcbusy = 1;
      for (int i = 0; i < 5; i++) begin
         set_push(32'h600 + 32'(i * 8), 64'(i));
         tick();
      end
      push = 0;
      #2 reset = 1;
      #1;
      n_chk++; if (dcwrite !== 1'b0 || count !== 3'd0 || ovfl !== 1'b0 || empty !== 1'b1)
         begin n_fail++; $display("FAIL async_reset got dcwrite=%b count=%0d ovfl=%b want 0/0/0", dcwrite, count, ovfl); end
      q.delete();
      m_ovfl = 0;
      @(negedge clk);
      reset = 0; dcbusy = 0;
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         phi2       = $urandom_range(0, 3) != 0;
         push       = $urandom_range(0, 1);
         push_pa    = 32'h1000 + 32'($urandom_range(0, 7) * 8 + $urandom_range(0, 7));
         push_data  = {$urandom, $urandom};
         push_sz    = 3'($urandom_range(0, 7));
         push_cache = $urandom_range(0, 1);
         dcbusy     = $urandom_range(0, 2) == 0;
         ldreq      = $urandom_range(0, 1);
         ldpa       = 32'h1000 + 32'($urandom_range(0, 15) * 8 + $urandom_range(0, 7));
         ldcache    = $urandom_range(0, 4) != 0;
         #1;
         n_chk++; if (count !== CW'(q.size()) || empty !== (q.size() == 0) || full !== (q.size() == DEPTH))
            begin n_fail++; $display("FAIL rnd_count cyc=%0d got %0d/%b/%b want %0d", c, count, empty, full, q.size()); end
         n_chk++; if (dcwrite !== (q.size() > 0) || ovfl !== m_ovfl)
            begin n_fail++; $display("FAIL rnd_flags cyc=%0d got dcwrite=%b ovfl=%b want %b/%b", c, dcwrite, ovfl, q.size() > 0, m_ovfl); end
         n_chk++; if (ldconf !== exp_ldconf())
            begin n_fail++; $display("FAIL rnd_ldconf cyc=%0d got %b want %b", c, ldconf, exp_ldconf()); end
         if (q.size() > 0) begin
            n_chk++; if ({dcpa, dcwdata, dcsz, dccache} !== q[0])
               begin n_fail++; $display("FAIL rnd_head cyc=%0d got %h/%h want %h/%h", c, dcpa, dcwdata, q[0].pa, q[0].d); end
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_drain();
      test_overflow();
      test_hazard();
      test_uncached();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
